// File: rtl/pong_game_control.sv
// Pong game-level controller: serve, miss detection, scoring and game-over.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ball parked at centre, waiting for a Start press to serve
// RUNNING   | ball in play, watching both goal columns for a miss
// SCORED    | single cycle after a miss; decides IDLE or GAME_OVER
// GAME_OVER | score limit reached, winner latched, scores frozen
module pong_game_control #(
  parameter int c_GAME_WINDOW_WIDTH  = 40,
  parameter int c_GAME_WINDOW_HEIGHT = 30,
  parameter int c_PADDLE_HEIGHT      = 6,
  parameter int c_SCORE_LIMIT        = 9
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic [5:0] i_Ball_X_Position,
  input  logic [5:0] i_Ball_Y_Position,
  input  logic [5:0] i_Paddle_Y_P1,
  input  logic [5:0] i_Paddle_Y_P2,
  output logic       o_GameRunning,
  output logic [3:0] o_Score_P1,
  output logic [3:0] o_Score_P2,
  output logic       o_PointScored,
  output logic       o_GameOver,
  output logic       o_Winner
);

  localparam logic [5:0] c_GOAL_X_P2 = 6'(c_GAME_WINDOW_WIDTH - 1);
  localparam logic [6:0] c_ROWS      = 7'(c_GAME_WINDOW_HEIGHT);
  localparam logic [6:0] c_PAD_LEN   = 7'(c_PADDLE_HEIGHT);
  localparam logic [3:0] c_LIMIT     = 4'(c_SCORE_LIMIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUNNING   = 2'd1,
    SCORED    = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       start_d;
  logic       start_block;
  logic       start_edge;

  logic [6:0] ball_y;
  logic [6:0] pad_top_p1;
  logic [6:0] pad_top_p2;
  logic       row_valid;
  logic       hit_p1;
  logic       hit_p2;
  logic       miss_p1;
  logic       miss_p2;

  logic       running_next;
  logic       point_next;
  logic       over_next;
  logic       winner_next;
  logic [3:0] score_p1_next;
  logic [3:0] score_p2_next;

  // A button already held when reset is released must be let go before it can serve.
  assign start_edge = i_Start & ~start_d & ~start_block;

  // Hit test in 7 bits so a paddle hanging past the bottom row does not wrap.
  always_comb begin
    ball_y     = {1'b0, i_Ball_Y_Position};
    pad_top_p1 = {1'b0, i_Paddle_Y_P1};
    pad_top_p2 = {1'b0, i_Paddle_Y_P2};
    row_valid  = (ball_y < c_ROWS);
    hit_p1     = (ball_y >= pad_top_p1) && (ball_y < (pad_top_p1 + c_PAD_LEN));
    hit_p2     = (ball_y >= pad_top_p2) && (ball_y < (pad_top_p2 + c_PAD_LEN));
    miss_p1    = row_valid && (i_Ball_X_Position == 6'd0) && !hit_p1;
    miss_p2    = row_valid && (i_Ball_X_Position == c_GOAL_X_P2) && !hit_p2;
  end

  // Next state and next registered output values.
  always_comb begin
    state_next    = state;
    running_next  = 1'b0;
    point_next    = 1'b0;
    over_next     = 1'b0;
    winner_next   = o_Winner;
    score_p1_next = o_Score_P1;
    score_p2_next = o_Score_P2;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_next   = RUNNING;
          running_next = 1'b1;
        end
      end
      RUNNING: begin
        running_next = 1'b1;
        if (miss_p1) begin
          state_next    = SCORED;
          running_next  = 1'b0;
          point_next    = 1'b1;
          score_p2_next = o_Score_P2 + 4'd1;
        end else if (miss_p2) begin
          state_next    = SCORED;
          running_next  = 1'b0;
          point_next    = 1'b1;
          score_p1_next = o_Score_P1 + 4'd1;
        end
      end
      SCORED: begin
        // Only the side that just scored can be at the limit.
        if ((o_Score_P1 == c_LIMIT) || (o_Score_P2 == c_LIMIT)) begin
          state_next  = GAME_OVER;
          over_next   = 1'b1;
          winner_next = (o_Score_P2 == c_LIMIT);
        end else begin
          state_next  = IDLE;
        end
      end
      GAME_OVER: begin
        over_next = 1'b1;
        if (start_edge) begin
          state_next    = IDLE;
          over_next     = 1'b0;
          winner_next   = 1'b0;
          score_p1_next = 4'd0;
          score_p2_next = 4'd0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, registered outputs and start edge tracking.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= IDLE;
      o_GameRunning <= 1'b0;
      o_PointScored <= 1'b0;
      o_GameOver    <= 1'b0;
      o_Winner      <= 1'b0;
      o_Score_P1    <= 4'd0;
      o_Score_P2    <= 4'd0;
      start_d       <= 1'b0;
      start_block   <= i_Start;
    end else begin
      state         <= state_next;
      o_GameRunning <= running_next;
      o_PointScored <= point_next;
      o_GameOver    <= over_next;
      o_Winner      <= winner_next;
      o_Score_P1    <= score_p1_next;
      o_Score_P2    <= score_p2_next;
      start_d       <= i_Start;
      start_block   <= start_block & i_Start;
    end
  end

endmodule
